// File: rtl/hyperbus_pkg.sv
// ============================================================================
// hyperbus_pkg : shared types and helpers for the HyperBus burst splitter
// Rev 1.0
// ============================================================================
`default_nettype none

package hyperbus_pkg;

    localparam int C_ADDR_WIDTH           = 32;
    localparam int C_LEN_WIDTH            = 16;
    localparam int C_NUM_CHIPS            = 2;
    localparam int C_CHIP_SIZE_LOG2       = 23;
    localparam int C_MAX_BURST_WORDS      = 256;
    localparam int C_CHIP_WORD_ADDR_WIDTH = C_CHIP_SIZE_LOG2 - 1;

    typedef struct packed {
        logic [C_NUM_CHIPS-1:0]            cs;
        logic [C_CHIP_WORD_ADDR_WIDTH-1:0] addr;
        logic [C_LEN_WIDTH-1:0]            len;
        logic                              write;
        logic                              last;
    } tf_t;

    function automatic logic [C_LEN_WIDTH-1:0] min3(
        input logic [C_LEN_WIDTH-1:0] a,
        input logic [C_LEN_WIDTH-1:0] b,
        input logic [C_LEN_WIDTH-1:0] c
    );
        logic [C_LEN_WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hyperbus_burst_splitter.sv
// ============================================================================
// hyperbus_burst_splitter : splits linear word bursts into PHY transfers that
// never cross a chip boundary nor exceed the programmed burst limit.
// Rev 1.0
// ============================================================================
`default_nettype none

module hyperbus_burst_splitter
    import hyperbus_pkg::*;
#(
    parameter int ADDR_WIDTH      = C_ADDR_WIDTH,
    parameter int LEN_WIDTH       = C_LEN_WIDTH,
    parameter int NUM_CHIPS       = C_NUM_CHIPS,
    parameter int CHIP_SIZE_LOG2  = C_CHIP_SIZE_LOG2,
    parameter int MAX_BURST_WORDS = C_MAX_BURST_WORDS
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [LEN_WIDTH-1:0]      cfg_max_words_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic                      req_write_i,
    output logic                      tf_valid_o,
    input  logic                      tf_ready_i,
    output logic [NUM_CHIPS-1:0]      tf_cs_o,
    output logic [CHIP_SIZE_LOG2-2:0] tf_addr_o,
    output logic [LEN_WIDTH-1:0]      tf_len_o,
    output logic                      tf_write_o,
    output logic                      tf_last_o,
    output logic                      busy_o
);

    localparam int c_WORD_ADDR_WIDTH = ADDR_WIDTH - 1;
    localparam int c_CWA_WIDTH       = CHIP_SIZE_LOG2 - 1;
    localparam int c_CHIP_IDX_WIDTH  = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
    localparam logic [CHIP_SIZE_LOG2-1:0] c_CHIP_WORDS = {1'b1, {c_CWA_WIDTH{1'b0}}};

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SPLIT = 1'b1;

    logic [0:0]                   r_state;
    logic [c_WORD_ADDR_WIDTH-1:0] r_word_addr;
    logic [LEN_WIDTH-1:0]         r_remaining;
    logic [LEN_WIDTH-1:0]         r_limit;
    logic                         r_write;

    logic                         w_split;
    logic [c_CHIP_IDX_WIDTH-1:0]  w_chip_idx;
    logic [CHIP_SIZE_LOG2-1:0]    w_to_boundary;
    logic [LEN_WIDTH-1:0]         w_boundary_len;
    logic [LEN_WIDTH-1:0]         w_len;
    logic                         w_unused_addr_lsb;
    tf_t                          w_tf;

    assign w_split           = (r_state == c_S_SPLIT);
    assign w_unused_addr_lsb = req_addr_i[0];

    // Chip index bits sit just above the chip-relative word address; upper bits wrap.
    if (NUM_CHIPS > 1) begin : g_multi_chip
        assign w_chip_idx = r_word_addr[c_CWA_WIDTH +: c_CHIP_IDX_WIDTH];
    end else begin : g_single_chip
        assign w_chip_idx = '0;
    end

    assign w_to_boundary = c_CHIP_WORDS - {1'b0, r_word_addr[c_CWA_WIDTH-1:0]};

    // The distance to the boundary can exceed the length range; saturate before the min.
    if (CHIP_SIZE_LOG2 > LEN_WIDTH) begin : g_boundary_sat
        assign w_boundary_len = (|w_to_boundary[CHIP_SIZE_LOG2-1:LEN_WIDTH]) ? '1
                                                                              : w_to_boundary[LEN_WIDTH-1:0];
    end else begin : g_boundary_ext
        assign w_boundary_len = LEN_WIDTH'(w_to_boundary);
    end

    assign w_len = min3(r_remaining, r_limit, w_boundary_len);

    assign w_tf.cs    = w_split ? (NUM_CHIPS'(1) << w_chip_idx) : '0;
    assign w_tf.addr  = w_split ? r_word_addr[c_CWA_WIDTH-1:0] : '0;
    assign w_tf.len   = w_split ? w_len : '0;
    assign w_tf.write = w_split & r_write;
    assign w_tf.last  = w_split & (w_len == r_remaining);

    assign req_ready_o = ~w_split;
    assign busy_o      = w_split;
    assign tf_valid_o  = w_split;
    assign tf_cs_o     = w_tf.cs;
    assign tf_addr_o   = w_tf.addr;
    assign tf_len_o    = w_tf.len;
    assign tf_write_o  = w_tf.write;
    assign tf_last_o   = w_tf.last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= c_S_IDLE;
            r_word_addr <= '0;
            r_remaining <= '0;
            r_limit     <= '0;
            r_write     <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    // Zero-length requests are consumed without leaving IDLE.
                    if (req_valid_i && (req_len_i != '0)) begin
                        r_word_addr <= req_addr_i[ADDR_WIDTH-1:1];
                        r_remaining <= req_len_i;
                        r_write     <= req_write_i;
                        r_limit     <= (cfg_max_words_i == '0) ? LEN_WIDTH'(MAX_BURST_WORDS)
                                                               : cfg_max_words_i;
                        r_state     <= c_S_SPLIT;
                    end
                end
                c_S_SPLIT: begin
                    if (tf_ready_i) begin
                        r_word_addr <= r_word_addr + c_WORD_ADDR_WIDTH'(w_len);
                        r_remaining <= r_remaining - w_len;
                        if (w_tf.last) begin
                            r_state <= c_S_IDLE;
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hyperbus_burst_splitter.sv
// ============================================================================
// tb_hyperbus_burst_splitter : directed, table-driven bench for the splitter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hyperbus_burst_splitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_max_words = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        req_write = 1'b0;
    logic        tf_valid;
    logic        tf_ready = 1'b0;
    logic [1:0]  tf_cs;
    logic [21:0] tf_addr;
    logic [15:0] tf_len;
    logic        tf_write;
    logic        tf_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hyperbus_burst_splitter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cfg_max_words_i (cfg_max_words),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_len_i       (req_len),
        .req_write_i     (req_write),
        .tf_valid_o      (tf_valid),
        .tf_ready_i      (tf_ready),
        .tf_cs_o         (tf_cs),
        .tf_addr_o       (tf_addr),
        .tf_len_o        (tf_len),
        .tf_write_o      (tf_write),
        .tf_last_o       (tf_last),
        .busy_o          (busy)
    );

    typedef struct {
        bit          new_req;
        logic [31:0] addr;
        logic [15:0] len;
        logic [15:0] cfg;
        logic        wr;
        logic [1:0]  cs;
        logic [21:0] taddr;
        logic [15:0] tlen;
        logic        last;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [15:0] len,
                          input logic [15:0] cfg, input logic wr);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_before_req", 32'(req_ready), 32'd1);
        cfg_max_words = cfg;
        req_addr      = addr;
        req_len       = len;
        req_write     = wr;
        req_valid     = 1'b1;
        @(posedge clk); #1;
        req_valid     = 1'b0;
    endtask

    task automatic expect_tf(input string name, input logic [1:0] cs, input logic [21:0] addr,
                             input logic [15:0] len, input logic wr, input logic last);
        int n = 0;
        while (!tf_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, ".valid"}, 32'(tf_valid), 32'd1);
        check({name, ".cs"},    32'(tf_cs),    32'(cs));
        check({name, ".addr"},  32'(tf_addr),  32'(addr));
        check({name, ".len"},   32'(tf_len),   32'(len));
        check({name, ".write"}, 32'(tf_write), 32'(wr));
        check({name, ".last"},  32'(tf_last),  32'(last));
        tf_ready = 1'b1;
        @(posedge clk); #1;
        tf_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;

        // Expected transfers, worked out by hand from address/length/limit.
        vecs[0] = '{1'b1, 32'h0000_0000, 16'd600, 16'd0, 1'b0, 2'b01, 22'h000000, 16'd256, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         16'd0,   16'd0, 1'b0, 2'b01, 22'h000100, 16'd256, 1'b0};
        vecs[2] = '{1'b0, 32'h0,         16'd0,   16'd0, 1'b0, 2'b01, 22'h000200, 16'd88,  1'b1};
        vecs[3] = '{1'b1, 32'h007F_FFF0, 16'd16,  16'd0, 1'b1, 2'b01, 22'h3FFFF8, 16'd8,   1'b0};
        vecs[4] = '{1'b0, 32'h0,         16'd0,   16'd0, 1'b1, 2'b10, 22'h000000, 16'd8,   1'b1};
        vecs[5] = '{1'b1, 32'h0100_0000, 16'd4,   16'd0, 1'b0, 2'b01, 22'h000000, 16'd4,   1'b1};
        vecs[6] = '{1'b1, 32'h0080_0000, 16'd3,   16'd2, 1'b1, 2'b10, 22'h000000, 16'd2,   1'b0};
        vecs[7] = '{1'b0, 32'h0,         16'd0,   16'd0, 1'b1, 2'b10, 22'h000002, 16'd1,   1'b1};

        #12;
        check("rst.tf_valid", 32'(tf_valid), 32'd0);
        check("rst.tf_cs",    32'(tf_cs),    32'd0);
        check("rst.tf_addr",  32'(tf_addr),  32'd0);
        check("rst.tf_len",   32'(tf_len),   32'd0);
        check("rst.tf_write", 32'(tf_write), 32'd0);
        check("rst.tf_last",  32'(tf_last),  32'd0);
        check("rst.busy",     32'(busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst.req_ready", 32'(req_ready), 32'd1);

        // Single request, PHY stalls one cycle: ready is low for two cycles.
        do_req(32'h0000_0100, 16'd16, 16'd0, 1'b0);
        check("single.valid", 32'(tf_valid), 32'd1);
        check("single.cs",    32'(tf_cs),    32'd1);
        check("single.addr",  32'(tf_addr),  32'h80);
        check("single.len",   32'(tf_len),   32'd16);
        check("single.last",  32'(tf_last),  32'd1);
        check("single.busy",  32'(busy),     32'd1);
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready) break;
            low_cnt++;
            if (low_cnt == 2) tf_ready = 1'b1;
            @(posedge clk); #1;
            tf_ready = 1'b0;
        end
        check("single.ready_low_cycles", 32'(low_cnt), 32'd2);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].new_req) do_req(vecs[i].addr, vecs[i].len, vecs[i].cfg, vecs[i].wr);
            expect_tf($sformatf("vec%0d", i), vecs[i].cs, vecs[i].taddr, vecs[i].tlen,
                      vecs[i].wr, vecs[i].last);
        end

        // Back-pressure with a config change mid-burst that must be ignored.
        do_req(32'h0, 16'd10, 16'd4, 1'b1);
        cfg_max_words = 16'd1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d.valid", i), 32'(tf_valid), 32'd1);
            check($sformatf("bp%0d.len", i),   32'(tf_len),   32'd4);
            check($sformatf("bp%0d.addr", i),  32'(tf_addr),  32'd0);
            check($sformatf("bp%0d.last", i),  32'(tf_last),  32'd0);
            check($sformatf("bp%0d.write", i), 32'(tf_write), 32'd1);
            @(posedge clk); #1;
        end
        expect_tf("bp_t0", 2'b01, 22'd0, 16'd4, 1'b1, 1'b0);
        expect_tf("bp_t1", 2'b01, 22'd4, 16'd4, 1'b1, 1'b0);
        expect_tf("bp_t2", 2'b01, 22'd8, 16'd2, 1'b1, 1'b1);
        cfg_max_words = 16'd0;

        // Zero-length request is consumed with no transfer.
        do_req(32'h0000_0200, 16'd0, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("len0_%0d.valid", i), 32'(tf_valid),  32'd0);
            check($sformatf("len0_%0d.ready", i), 32'(req_ready), 32'd1);
            @(posedge clk); #1;
        end

        // Asynchronous reset during the second transfer abandons the request.
        do_req(32'h0, 16'd600, 16'd0, 1'b0);
        expect_tf("rb_t0", 2'b01, 22'h0, 16'd256, 1'b0, 1'b0);
        check("rb_t1.len",  32'(tf_len),  32'd256);
        check("rb_t1.addr", 32'(tf_addr), 32'h100);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb.tf_valid", 32'(tf_valid), 32'd0);
        check("rb.tf_len",   32'(tf_len),   32'd0);
        check("rb.tf_cs",    32'(tf_cs),    32'd0);
        check("rb.tf_addr",  32'(tf_addr),  32'd0);
        check("rb.busy",     32'(busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(32'h0000_0040, 16'd2, 16'd0, 1'b0);
        expect_tf("after_rst", 2'b01, 22'h20, 16'd2, 1'b0, 1'b1);
        check("after_rst.idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hyperbus_burst_splitter.md
Name: hyperbus_burst_splitter

Overview:
Sits between the AXI front-end and the HyperBus PHY command path inside the hyperbus controller. Takes linear word-burst requests (byte address plus 16-bit word count) and splits them into PHY transfers. No transfer crosses a chip boundary or exceeds the programmed maximum burst length, which keeps CS# low time within the tCSM limit. Each transfer carries a one-hot chip select and a chip-relative word address.

Parameters:
AddrWidth, 32, request byte-address width
LenWidth, 16, word-count width for requests and transfers
NumChips, 2, number of HyperBus chips; must be a power of two, at least 1
ChipSizeLog2, 23, log2 of bytes per chip (8 MiB = s27ks0641)
MaxBurstWords, 256, hard cap on words per transfer; used when the configured limit is 0

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_max_words_i  in  LenWidth  programmed max words per transfer (from regbus config); 0 selects MaxBurstWords
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid and ready are both high
req_addr_i  in  AddrWidth  byte start address; bit 0 ignored
req_len_i  in  LenWidth  number of 16-bit words
req_write_i  in  1  1 = write, 0 = read
tf_valid_o  out  1  transfer valid
tf_ready_i  in  1  PHY accepts transfer
tf_cs_o  out  NumChips  one-hot chip select
tf_addr_o  out  ChipSizeLog2-1  chip-relative word address
tf_len_o  out  LenWidth  words in this transfer (always at least 1)
tf_write_o  out  1  direction copied from the request
tf_last_o  out  1  last transfer of the current request
busy_o  out  1  high in SPLIT state

Behaviour:
- Reset values: tf_valid_o=0, tf_cs_o=0, tf_addr_o=0, tf_len_o=0, tf_write_o=0, tf_last_o=0, busy_o=0. req_ready_o=1 once reset is released.
- FSM has two states: IDLE and SPLIT.
- IDLE:
  - req_ready_o=1.
  - On handshake with req_len_i!=0: register the word address (req_addr_i[AddrWidth-1:1]), remaining=req_len_i, write flag, and limit (cfg_max_words_i, or MaxBurstWords if it is 0). Go to SPLIT.
  - On handshake with req_len_i==0: the request is consumed, no transfer is emitted, state stays IDLE.
- SPLIT:
  - req_ready_o=0 and tf_valid_o=1.
  - Chip index = word_addr[ChipSizeLog2-1 +: log2(NumChips)], so addresses above NumChips chips wrap modulo.
  - tf_cs_o = one-hot of the chip index.
  - tf_addr_o = word_addr[ChipSizeLog2-2:0].
  - to_boundary = 2^(ChipSizeLog2-1) - tf_addr_o, computed in ChipSizeLog2 bits.
  - tf_len_o = min(remaining, limit, to_boundary), computed combinationally from registered state.
  - tf_last_o = (tf_len_o == remaining).
- Transfer handshake (tf_valid_o && tf_ready_i): word_addr += tf_len_o, remaining -= tf_len_o. If tf_last_o, go to IDLE.
- Latency: first tf_valid_o one cycle after the request handshake. One transfer per cycle if tf_ready_i is held high. At least one IDLE cycle between requests.
- While tf_valid_o && !tf_ready_i, all tf_* outputs stay stable. cfg_max_words_i changes during SPLIT have no effect; the limit is sampled only at request accept.
- Address arithmetic wraps at 2^(AddrWidth-1) words.
- Asynchronous reset mid-burst abandons the request: state IDLE, all outputs at reset values.

Decomposition:
- hyperbus_pkg holds:
  - the tf_t struct (cs, addr, len, write, last)
  - a function computing the minimum of three LenWidth values
  - ChipWordAddrWidth = ChipSizeLog2-1
- No sub-module; the FSM and arithmetic are a single module.

Test Plan:
- Single request: addr 0x0000_0100, len 16, cfg 0 -> one transfer: cs=01, addr 0x80, len 16, last=1; req_ready_o low for exactly 2 cycles.
- Max-burst split: addr 0x0, len 600, cfg 0 -> transfers of len 256 @0x0, 256 @0x100, 88 @0x200; last only on the third.
- Chip-boundary split: addr 0x007F_FFF0, len 16 -> cs=01 addr 0x3FFFF8 len 8 last=0, then cs=10 addr 0x0 len 8 last=1.
- Back-pressure: tf_ready_i low for 5 cycles on the first transfer of the cfg=4, len 10 case -> outputs stable, then lengths 4, 4, 2.
- len 0 request -> accepted, no tf_valid_o. Chip-index wrap: addr 0x0100_0000 -> cs=01.
- Reset asserted during the second transfer of the len 600 request -> tf_valid_o=0 immediately. The next request (addr 0x40, len 2) produces a single transfer: addr 0x20, len 2.
